// File: rtl/boa_pkg.sv
// boa_pkg: shared types and constants for the boa memory responder.
//   boa_memresp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   BOA_MEM_MAX_LATENCY : largest supported wait-state count
//   boa_memresp_cnt_t   : wait-state counter wide enough for the maximum latency
package boa_pkg;
  localparam int BOA_MEM_MAX_LATENCY = 15;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} boa_memresp_state_t;
  typedef logic [$clog2(BOA_MEM_MAX_LATENCY + 1)-1:0] boa_memresp_cnt_t;
endpackage

// File: rtl/boa_mem_bus.sv
// boa_mem_bus: pipeline-to-memory request/response bus.
//   re, we[3:0], addr[31:2], wdata : request from the initiator
//   rdata, ready                   : response from the memory
//   MEM : responder modport, CPU : initiator modport
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:2] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_sram_rf.sv
// boa_sram_rf: single-port read-first RAM with byte enables and registered read port.
module boa_sram_rf #(
  parameter int    abits     = 12,
  parameter string init_file = ""
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [abits-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      q
);
  logic [31:0] mem [2**abits];
  always_ff @(posedge clk) begin
    if (en) begin
      q <= mem[idx];
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/boa_mem_responder.sv
// boa_mem_responder: word-addressed RAM/ROM answering boa_mem_bus requests after a fixed number of wait states.
//   clk : clock
//   rst : synchronous reset, active low
//   bus : responder side of boa_mem_bus (request in, rdata/ready out)
module boa_mem_responder
  import boa_pkg::*;
#(
  parameter int    abits     = 12,
  parameter int    latency   = 0,
  parameter string init_file = "",
  parameter bit    writable  = 1'b1
) (
  input logic     clk,
  input logic     rst,
  boa_mem_bus.MEM bus
);
  localparam boa_memresp_cnt_t lat_m1 = latency == 0 ? '0 : boa_memresp_cnt_t'(latency - 1);
  boa_memresp_state_t state_q, state_d;
  boa_memresp_cnt_t   cnt_q, cnt_d;
  logic [31:2] addr_q;
  logic        re_q;
  logic [31:0] hold_q, q, resp;
  logic        req, cancel, open, accept;
  assign req = bus.re || |bus.we;
  // A redirect while waiting: a different read address, or the read withdrawn.
  assign cancel = (bus.re && bus.we == '0 && bus.addr != addr_q) || (re_q && !bus.re);
  assign open   = state_q != WAIT || cancel;
  assign accept = open && req;
  boa_sram_rf #(.abits(abits), .init_file(init_file)) u_ram (
    .clk   (clk),
    .en    (accept && rst),
    .we    (writable ? bus.we : 4'b0),
    .idx   (bus.addr[abits+1:2]),
    .wdata (bus.wdata),
    .q     (q)
  );
  always_comb begin
    state_d = accept ? (latency == 0 ? RESP : WAIT) : open ? IDLE : (cnt_q == '0 ? RESP : WAIT);
    cnt_d   = accept ? lat_m1 : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= bus.addr;
        re_q   <= bus.re;
      end
      if (state_q == RESP) hold_q <= resp;
    end
  end
  assign resp      = re_q ? q : 32'h0;
  assign bus.ready = state_q == RESP;
  assign bus.rdata = bus.ready ? resp : hold_q;
endmodule
